bpred_sdp_ram: RTL and testbench

- Parameterised simple dual-port synchronous RAM: one write port and one read port, sharing one clock.
- It is the storage primitive for the branch-predictor front end. It is instanced three times:
  - perceptron high-order-bit weight table: 36 b x 64;
  - perceptron low-order-bit weight table: 60 b x 64;
  - instruction memory: 32 b x 256.
- The read address is presented combinationally before a clock edge. Read data is valid after that edge.

---
 rtl/bpred_sdp_ram.sv | 48 ++++
 tb/tb_bpred_sdp_ram.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bpred_sdp_ram.sv
// Simple dual-port synchronous RAM (one write port, one registered read port) for the branch predictor.
// Optional macro BPRED_SDP_RAM_BYPASS_EN forwards write data to q on a same-edge read/write collision.
module bpred_sdp_ram #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] wraddress,
    input  logic                  wren,
    input  logic [ADDR_WIDTH-1:0] rdaddress,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Power-up contents are all zero; reset never clears the array so it maps onto block/MLAB RAM.
    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_word_p0;

    always_ff @(posedge clock) begin
        if (wren && reset_n) begin
            mem[wraddress] <= data;
        end
    end

`ifdef BPRED_SDP_RAM_BYPASS_EN
    always_comb begin
        rd_word_p0 = mem[rdaddress];
        if (wren && (wraddress == rdaddress)) begin
            rd_word_p0 = data;
        end
    end
`else
    assign rd_word_p0 = mem[rdaddress];
`endif

    // Stage p0 -> q: the only register carrying a reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else begin
            q <= rd_word_p0;
        end
    end

endmodule

// File: tb/tb_bpred_sdp_ram.sv
// Self-checking bench for bpred_sdp_ram: directed vector table, hand sequences and a randomized
// run against an array-based reference model; also exercises a 60 b x 64 instance.
module tb_bpred_sdp_ram;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] data;
    logic [7:0]  wraddress;
    logic        wren;
    logic [7:0]  rdaddress;
    logic [31:0] q;

    logic        reset_n60;
    logic [59:0] data60;
    logic [5:0]  wa60;
    logic        wren60;
    logic [5:0]  ra60;
    logic [59:0] q60;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_m [256];
    logic [31:0] q_m;

    typedef struct {
        bit          we;
        logic [7:0]  wa;
        logic [31:0] d;
        logic [7:0]  ra;
        logic [31:0] exp_q;
    } vec_t;

    vec_t vecs [16];

    always #5 clock = ~clock;

    bpred_sdp_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .data     (data),
        .wraddress(wraddress),
        .wren     (wren),
        .rdaddress(rdaddress),
        .q        (q)
    );

    bpred_sdp_ram #(.DATA_WIDTH(60), .ADDR_WIDTH(6)) dut60 (
        .clock    (clock),
        .reset_n  (reset_n60),
        .data     (data60),
        .wraddress(wa60),
        .wren     (wren60),
        .rdaddress(ra60),
        .q        (q60)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // One clock edge; the reference model applies the storage rules at the same edge.
    task automatic step(input bit we, input logic [7:0] wa, input logic [31:0] d, input logic [7:0] ra);
        wren      = we;
        wraddress = wa;
        data      = d;
        rdaddress = ra;
        @(posedge clock);
        if (reset_n) begin
`ifdef BPRED_SDP_RAM_BYPASS_EN
            q_m = (we && wa == ra) ? d : mem_m[ra];
`else
            q_m = mem_m[ra];
`endif
            if (we) mem_m[wa] = d;
        end else begin
            q_m = '0;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] coll_exp;
        logic [59:0] all_ones60;
        logic [59:0] pat60;

        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        q_m = '0;

        vecs[0]  = '{1'b1, 8'h10, 32'h1234_5678, 8'h00, 32'h0000_0000};
        vecs[1]  = '{1'b0, 8'h00, 32'h0000_0000, 8'h10, 32'h1234_5678};
        vecs[2]  = '{1'b1, 8'h00, 32'h0000_00A0, 8'h10, 32'h1234_5678};
        vecs[3]  = '{1'b1, 8'h01, 32'h0000_00A1, 8'h00, 32'h0000_00A0};
        vecs[4]  = '{1'b1, 8'h02, 32'h0000_00A2, 8'h01, 32'h0000_00A1};
        vecs[5]  = '{1'b1, 8'h03, 32'h0000_00A3, 8'h02, 32'h0000_00A2};
        vecs[6]  = '{1'b0, 8'h00, 32'h0000_0000, 8'h03, 32'h0000_00A3};
        vecs[7]  = '{1'b0, 8'h00, 32'h0000_0000, 8'h00, 32'h0000_00A0};
        vecs[8]  = '{1'b0, 8'h00, 32'h0000_0000, 8'h01, 32'h0000_00A1};
        vecs[9]  = '{1'b0, 8'h00, 32'h0000_0000, 8'h02, 32'h0000_00A2};
        vecs[10] = '{1'b0, 8'h00, 32'h0000_0000, 8'h03, 32'h0000_00A3};
        vecs[11] = '{1'b0, 8'hFF, 32'h0000_FFFF, 8'h00, 32'h0000_00A0};
        vecs[12] = '{1'b0, 8'h00, 32'h0000_0000, 8'hFF, 32'h0000_0000};
        vecs[13] = '{1'b1, 8'hFF, 32'hCAFE_F00D, 8'h01, 32'h0000_00A1};
        vecs[14] = '{1'b1, 8'h00, 32'h5A5A_5A5A, 8'hFF, 32'hCAFE_F00D};
        vecs[15] = '{1'b0, 8'h00, 32'h0000_0000, 8'h00, 32'h5A5A_5A5A};

        reset_n   = 1'b0;
        reset_n60 = 1'b0;
        wren = 1'b0; wraddress = '0; data = '0; rdaddress = '0;
        wren60 = 1'b0; wa60 = '0; data60 = '0; ra60 = '0;
        #1;
        chk("reset_q_t0", {32'h0, q}, 64'h0);
        chk("reset_q60_t0", {4'h0, q60}, 64'h0);
        @(posedge clock);
        #1;
        reset_n   = 1'b1;
        reset_n60 = 1'b1;

        // Reset: array survives, q forced low asynchronously, writes inhibited.
        step(1'b1, 8'h05, 32'hDEAD_BEEF, 8'h00);
        chk("preload_read0", {32'h0, q}, 64'h0);
        reset_n = 1'b0;
        #1;
        chk("reset_async_q", {32'h0, q}, 64'h0);
        step(1'b1, 8'h05, 32'h0000_0000, 8'h05);
        chk("reset_hold_q_a", {32'h0, q}, 64'h0);
        step(1'b1, 8'h05, 32'h0000_0000, 8'h05);
        chk("reset_hold_q_b", {32'h0, q}, 64'h0);
        reset_n = 1'b1;
        step(1'b0, 8'h00, 32'h0, 8'h05);
        chk("post_reset_read5", {32'h0, q}, 64'hDEAD_BEEF);

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].we, vecs[i].wa, vecs[i].d, vecs[i].ra);
            chk($sformatf("vec%0d", i), {32'h0, q}, {32'h0, vecs[i].exp_q});
        end

        // Read-during-write collision on address 7.
`ifdef BPRED_SDP_RAM_BYPASS_EN
        coll_exp = 32'h0000_2222;
`else
        coll_exp = 32'h0000_1111;
`endif
        step(1'b1, 8'h07, 32'h0000_1111, 8'h00);
        chk("coll_pre", {32'h0, q}, 64'h5A5A_5A5A);
        step(1'b1, 8'h07, 32'h0000_2222, 8'h07);
        chk("coll_same_edge", {32'h0, q}, {32'h0, coll_exp});
        step(1'b0, 8'h00, 32'h0, 8'h07);
        chk("coll_next_read", {32'h0, q}, 64'h2222);

        // Randomized traffic, addresses biased to a small window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] wa;
            logic [7:0] ra;
            wa = (i % 2 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            ra = (i % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7));
            step(1'($urandom_range(0, 1)), wa, $urandom, ra);
            chk("rand", {32'h0, q}, {32'h0, q_m});
        end
        wren = 1'b0;

        // 60 b x 64 instance.
        all_ones60 = 60'hFFF_FFFF_FFFF_FFFF;
        pat60      = 60'h123_4567_89AB_CDEF;
        wren60 = 1'b1; wa60 = 6'd63; data60 = all_ones60; ra60 = 6'd0;
        @(posedge clock); #1;
        chk("w60_read0", {4'h0, q60}, 64'h0);
        wa60 = 6'd0; data60 = pat60; ra60 = 6'd63;
        @(posedge clock); #1;
        chk("w60_read63", {4'h0, q60}, {4'h0, all_ones60});
        wren60 = 1'b0; ra60 = 6'd0;
        @(posedge clock); #1;
        chk("w60_read0_pat", {4'h0, q60}, {4'h0, pat60});
        ra60 = 6'd63;
        @(posedge clock); #1;
        chk("w60_before_pulse", {4'h0, q60}, {4'h0, all_ones60});
        #2;
        reset_n60 = 1'b0;
        #1;
        chk("w60_async_pulse", {4'h0, q60}, 64'h0);
        @(posedge clock); #1;
        chk("w60_reset_hold", {4'h0, q60}, 64'h0);
        reset_n60 = 1'b1;
        @(posedge clock); #1;
        chk("w60_after_pulse", {4'h0, q60}, {4'h0, all_ones60});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
